// File: rtl/dual_debounce_fsm.sv
// Two-channel switch debouncer: shared sample prescaler, per-channel 2-flop
// synchronizer, four-state debounce FSM, stability counter and rising-edge tick.
module dual_debounce_fsm #(
  parameter int CNT_W        = 19,
  parameter int STABLE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_a,
  input  logic       sw_b,
  output logic       a,
  output logic       b,
  output logic       a_tick,
  output logic       b_tick,
  output logic [1:0] state_a,
  output logic [1:0] state_b
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [3:0] RELOAD = 4'(STABLE_TICKS - 1);

  logic [CNT_W-1:0] q;
  logic             smp;
  logic [1:0]       sw_v;
  logic [1:0]       level_v;
  logic [1:0]       tick_v;
  logic [1:0]       st_v [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= q + 1'b1;
  end

  // Single sample strobe shared by both channels, once per prescaler wrap.
  assign smp  = &q;
  assign sw_v = {sw_b, sw_a};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [1:0] sync;
    logic       s;
    state_t     st, st_nxt;
    logic [3:0] c, c_nxt;
    logic       tick_r, tick_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= 2'b00;
      else          sync <= {sync[0], sw_v[i]};
    end

    assign s = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st     <= ZERO;
        c      <= 4'd0;
        tick_r <= 1'b0;
      end else begin
        st     <= st_nxt;
        c      <= c_nxt;
        tick_r <= tick_nxt;
      end
    end

    // Waiting states fall back as soon as s disagrees; they only advance on smp.
    always_comb begin
      st_nxt   = st;
      c_nxt    = c;
      tick_nxt = 1'b0;
      case (st)
        ZERO: begin
          if (s) begin
            st_nxt = WAIT1;
            c_nxt  = RELOAD;
          end
        end
        WAIT1: begin
          if (!s) begin
            st_nxt = ZERO;
          end else if (smp) begin
            if (c == 4'd0) begin
              st_nxt   = ONE;
              tick_nxt = 1'b1;
            end else begin
              c_nxt = c - 4'd1;
            end
          end
        end
        ONE: begin
          if (!s) begin
            st_nxt = WAIT0;
            c_nxt  = RELOAD;
          end
        end
        WAIT0: begin
          if (s) begin
            st_nxt = ONE;
          end else if (smp) begin
            if (c == 4'd0) st_nxt = ZERO;
            else           c_nxt  = c - 4'd1;
          end
        end
        default: st_nxt = ZERO;
      endcase
    end

    assign level_v[i] = (st == ONE) || (st == WAIT0);
    assign tick_v[i]  = tick_r;
    assign st_v[i]    = st;
  end

  assign a       = level_v[0];
  assign b       = level_v[1];
  assign a_tick  = tick_v[0];
  assign b_tick  = tick_v[1];
  assign state_a = st_v[0];
  assign state_b = st_v[1];

endmodule

// File: tb/tb_dual_debounce_fsm.sv
// Bench for dual_debounce_fsm: scenario tasks compared against a run-length
// reference model of the debounce rule, plus randomized switch activity.
module tb_dual_debounce_fsm;

  localparam int CNT_W  = 2;
  localparam int ST     = 3;
  localparam int PERIOD = 1 << CNT_W;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_a    = 1'b0;
  logic       sw_b    = 1'b0;
  logic       a, b, a_tick, b_tick;
  logic [1:0] state_a, state_b;

  int tests_run = 0;
  int failures  = 0;

  dual_debounce_fsm #(.CNT_W(CNT_W), .STABLE_TICKS(ST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_a    (sw_a),
    .sw_b    (sw_b),
    .a       (a),
    .b       (b),
    .a_tick  (a_tick),
    .b_tick  (b_tick),
    .state_a (state_a),
    .state_b (state_b)
  );

  always #5 clk = ~clk;

  // Reference: the level flips once the synchronized input has disagreed with
  // it for an unbroken run containing ST sample strobes after the run's first clock.
  int         m_q;
  logic [1:0] m_s1, m_s2, m_lvl, m_tick;
  int         m_run [2];
  int         m_cnt [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q = 0; m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_tick = 2'b00;
      m_run = '{0, 0}; m_cnt = '{0, 0};
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_tick[ch] = 1'b0;
        if (m_s2[ch] != m_lvl[ch]) begin
          if (m_run[ch] > 0 && m_q == PERIOD - 1) m_cnt[ch]++;
          m_run[ch]++;
          if (m_cnt[ch] == ST) begin
            m_lvl[ch]  = ~m_lvl[ch];
            m_tick[ch] = m_lvl[ch];
            m_run[ch]  = 0;
            m_cnt[ch]  = 0;
          end
        end else begin
          m_run[ch] = 0;
          m_cnt[ch] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {sw_b, sw_a};
      m_q  = (m_q + 1) % PERIOD;
    end
  end

  logic [3:0] obs, exp_v;
  assign obs   = {a, b, a_tick, b_tick};
  assign exp_v = {m_lvl[0], m_lvl[1], m_tick[0], m_tick[1]};

  task automatic test_reset();
    int ticks = 0, rise = -1;
    sw_a = 1'b1; sw_b = 1'b1; reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", i, obs);
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_release_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (a_tick) ticks++;
      if (a && rise < 0) rise = i;
    end
    tests_run++;
    if (rise - 1 < 11 || rise - 1 > 14) begin
      failures++;
      $display("FAIL reset_release_latency got=%0d want=11..14", rise - 1);
    end
    tests_run++;
    if (ticks != 1) begin
      failures++;
      $display("FAIL reset_release_ticks got=%0d want=1", ticks);
    end
  endtask

  task automatic test_clean_press();
    int ticks = 0, rise = -1, tick_at = -1, b_seen = 0;
    sw_a = 1'b0; sw_b = 1'b0;
    repeat (30) @(negedge clk);
    sw_a = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL clean_press_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (a_tick) begin ticks++; if (tick_at < 0) tick_at = i; end
      if (a && rise < 0) rise = i;
      if (b || b_tick) b_seen++;
    end
    tests_run++;
    if (ticks != 1) begin
      failures++;
      $display("FAIL clean_press_ticks got=%0d want=1", ticks);
    end
    tests_run++;
    if (rise < 0 || tick_at != rise) begin
      failures++;
      $display("FAIL clean_press_tick_align got=%0d want=%0d", tick_at, rise);
    end
    tests_run++;
    if (b_seen != 0) begin
      failures++;
      $display("FAIL clean_press_b_quiet got=%0d want=0", b_seen);
    end
  endtask

  task automatic test_bounce();
    int ticks = 0, bounce_ticks = 0, tick_at = -1;
    logic [3:0] pat;
    pat = 4'b0101;
    sw_a = 1'b0;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sw_a = pat[k];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        tests_run++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL bounce_model cyc=%0d got=%b want=%b", i, obs, exp_v);
        end
        if (a_tick) bounce_ticks++;
      end
    end
    sw_a = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL bounce_hold_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (a_tick) begin ticks++; if (tick_at < 0) tick_at = i; end
    end
    tests_run++;
    if (bounce_ticks != 0) begin
      failures++;
      $display("FAIL bounce_glitch_ticks got=%0d want=0", bounce_ticks);
    end
    tests_run++;
    if (ticks != 1 || tick_at < 0 || tick_at > 2 + 14) begin
      failures++;
      $display("FAIL bounce_final_tick got=%0d@%0d want=1@<=16", ticks, tick_at);
    end
  endtask

  task automatic test_release_glitch();
    int ticks = 0, low_seen = 0, falls = 0;
    logic last;
    sw_a = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) sw_a = 1'b1;
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL glitch_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (!a) low_seen++;
      if (a_tick) ticks++;
    end
    tests_run++;
    if (low_seen != 0) begin
      failures++;
      $display("FAIL glitch_level_held got=%0d low cycles want=0", low_seen);
    end
    last = 1'b1;
    sw_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL release_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (last && !a) falls++;
      last = a;
      if (a_tick) ticks++;
    end
    tests_run++;
    if (falls != 1 || a !== 1'b0 || ticks != 0) begin
      failures++;
      $display("FAIL release_fall got falls=%0d a=%b ticks=%0d want 1,0,0", falls, a, ticks);
    end
  endtask

  task automatic test_simultaneous();
    int ta = 0, tb = 0;
    sw_a = 1'b0; sw_b = 1'b0;
    repeat (30) @(negedge clk);
    sw_a = 1'b1; sw_b = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v || a_tick !== b_tick) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (a_tick) ta++;
      if (b_tick) tb++;
    end
    tests_run++;
    if (ta != 1 || tb != 1) begin
      failures++;
      $display("FAIL simultaneous_ticks got=%0d/%0d want=1/1", ta, tb);
    end
  endtask

  task automatic test_mid_reset();
    int ticks = 0, rise = -1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (a !== 1'b0 || a_tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async got a=%b tick=%b want 0,0", a, a_tick);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL mid_reset_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
      if (a_tick) ticks++;
      if (a && rise < 0) rise = i;
    end
    tests_run++;
    if (ticks != 1 || rise < 13 || rise > 16) begin
      failures++;
      $display("FAIL mid_reset_requalify got ticks=%0d rise=%0d want 1, 13..16", ticks, rise);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) sw_a = ~sw_a;
      if ($urandom_range(0, 7) == 0) sw_b = ~sw_b;
      @(negedge clk);
      tests_run++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%b want=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
